// File: rtl/axi_pkg.sv
// Shared AXI response codes and FSM state encodings for the memory responder.
package axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } r_state_e;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } w_state_e;

endpackage

// File: rtl/axi_resp_mem.sv
// Byte-lane backing store: byte-enable write port and registered read port;
// a read and a write to the same word on one edge return the old data.
module axi_resp_mem #(
  parameter int WORDS      = 1024,
  parameter int IDX_W      = $clog2(WORDS),
  parameter int DATA_WIDTH = 64
) (
  input  logic                    clk,
  input  logic                    re,
  input  logic [IDX_W-1:0]        raddr,
  output logic [DATA_WIDTH-1:0]   rdata,
  input  logic                    we,
  input  logic [IDX_W-1:0]        waddr,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic [DATA_WIDTH-1:0]   wdata
);

  // One narrow RAM per byte lane keeps the strobe a plain per-RAM write enable.
  for (genvar gi = 0; gi < DATA_WIDTH / 8; gi++) begin : g_lane
    logic [7:0] lane_mem [WORDS];
    logic [7:0] lane_q_reg;

    always_ff @(posedge clk) begin
      if (we && wstrb[gi]) begin
        lane_mem[waddr] <= wdata[8*gi +: 8];
      end
      if (re) begin
        lane_q_reg <= lane_mem[raddr];
      end
    end

    assign rdata[8*gi +: 8] = lane_q_reg;
  end

endmodule

// File: rtl/axi_mem_responder.sv
// AXI4 slave backed by a local word-addressed memory: independent read and
// write engines, INCR-only bursts, byte strobes, per-beat range checking.
module axi_mem_responder
  import axi_pkg::*;
#(
  parameter int                    ID_WIDTH   = 13,
  parameter int                    ADDR_WIDTH = 64,
  parameter int                    DATA_WIDTH = 64,
  parameter int                    STRB_WIDTH = DATA_WIDTH / 8,
  parameter int                    MEM_WORDS  = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ID_WIDTH-1:0]   s_axi_awid,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic [7:0]            s_axi_awlen,
  input  logic [2:0]            s_axi_awsize,
  input  logic [1:0]            s_axi_awburst,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [DATA_WIDTH-1:0] s_axi_wdata,
  input  logic [STRB_WIDTH-1:0] s_axi_wstrb,
  input  logic                  s_axi_wlast,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [ID_WIDTH-1:0]   s_axi_bid,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [ID_WIDTH-1:0]   s_axi_arid,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [7:0]            s_axi_arlen,
  input  logic [2:0]            s_axi_arsize,
  input  logic [1:0]            s_axi_arburst,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [ID_WIDTH-1:0]   s_axi_rid,
  output logic [DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rlast,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready
);

  localparam int                    IDX_W     = $clog2(MEM_WORDS);
  localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(DATA_WIDTH / 8);

  function automatic logic addr_in_range(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] off;
    off = a - BASE_ADDR;
    return (a >= BASE_ADDR) && ((off >> 3) < ADDR_WIDTH'(MEM_WORDS));
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] off;
    off = a - BASE_ADDR;
    return IDX_W'(off >> 3);
  endfunction

  // Burst size/type are fixed (8-byte INCR), so these fields carry no information.
  logic unused_inputs;
  assign unused_inputs = ^{s_axi_awsize, s_axi_awburst, s_axi_arsize, s_axi_arburst};

  // Read engine state
  r_state_e              r_state_reg, r_state_next;
  logic [ADDR_WIDTH-1:0] r_addr_reg, r_addr_next;
  logic [7:0]            r_len_reg, r_len_next;
  logic [8:0]            r_beat_reg, r_beat_next;
  logic [ID_WIDTH-1:0]   r_id_reg, r_id_next;
  logic                  r_last_reg, r_last_next;
  logic [1:0]            r_resp_reg, r_resp_next;
  logic                  r_zero_reg, r_zero_next;
  logic                  r_load;
  logic [ADDR_WIDTH-1:0] r_load_addr;

  // Write engine state
  w_state_e              w_state_reg, w_state_next;
  logic [ADDR_WIDTH-1:0] w_addr_reg, w_addr_next;
  logic [7:0]            w_len_reg, w_len_next;
  logic [8:0]            w_beat_reg, w_beat_next;
  logic [ID_WIDTH-1:0]   w_id_reg, w_id_next;
  logic                  w_err_reg, w_err_next;
  logic [1:0]            w_bresp_reg, w_bresp_next;
  logic                  w_last_beat, w_beat_ok, w_err_beat;

  logic                  mem_re, mem_we;
  logic [IDX_W-1:0]      mem_raddr;
  logic [DATA_WIDTH-1:0] mem_rdata;

  axi_resp_mem #(
    .WORDS      (MEM_WORDS),
    .IDX_W      (IDX_W),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_mem (
    .clk   (clk),
    .re    (mem_re),
    .raddr (mem_raddr),
    .rdata (mem_rdata),
    .we    (mem_we),
    .waddr (addr_idx(w_addr_reg)),
    .wstrb (s_axi_wstrb),
    .wdata (s_axi_wdata)
  );

  always_comb begin
    r_state_next = r_state_reg;
    r_addr_next  = r_addr_reg;
    r_len_next   = r_len_reg;
    r_beat_next  = r_beat_reg;
    r_id_next    = r_id_reg;
    r_last_next  = r_last_reg;
    r_resp_next  = r_resp_reg;
    r_zero_next  = r_zero_reg;
    r_load       = 1'b0;
    r_load_addr  = r_addr_reg + ADDR_STEP;

    unique case (r_state_reg)
      R_IDLE: begin
        if (s_axi_arvalid) begin
          r_load_addr  = s_axi_araddr;
          r_load       = 1'b1;
          r_id_next    = s_axi_arid;
          r_len_next   = s_axi_arlen;
          r_beat_next  = '0;
          r_last_next  = (s_axi_arlen == 8'd0);
          r_state_next = R_DATA;
        end
      end
      R_DATA: begin
        if (s_axi_rready) begin
          if (r_last_reg) begin
            r_state_next = R_IDLE;
          end else begin
            r_load      = 1'b1;
            r_beat_next = r_beat_reg + 9'd1;
            r_last_next = ((r_beat_reg + 9'd1) == {1'b0, r_len_reg});
          end
        end
      end
      default: r_state_next = R_IDLE;
    endcase

    // Every beat load fetches memory and registers its response in the same edge.
    if (r_load) begin
      r_addr_next = r_load_addr;
      r_resp_next = addr_in_range(r_load_addr) ? RESP_OKAY : RESP_SLVERR;
      r_zero_next = !addr_in_range(r_load_addr);
    end
  end

  assign mem_re    = r_load;
  assign mem_raddr = addr_idx(r_load_addr);

  assign w_last_beat = (w_beat_reg == {1'b0, w_len_reg});
  assign w_beat_ok   = addr_in_range(w_addr_reg);
  assign w_err_beat  = w_err_reg | ~w_beat_ok | (s_axi_wlast != w_last_beat);

  always_comb begin
    w_state_next = w_state_reg;
    w_addr_next  = w_addr_reg;
    w_len_next   = w_len_reg;
    w_beat_next  = w_beat_reg;
    w_id_next    = w_id_reg;
    w_err_next   = w_err_reg;
    w_bresp_next = w_bresp_reg;
    mem_we       = 1'b0;

    unique case (w_state_reg)
      W_IDLE: begin
        if (s_axi_awvalid) begin
          w_id_next    = s_axi_awid;
          w_addr_next  = s_axi_awaddr;
          w_len_next   = s_axi_awlen;
          w_beat_next  = '0;
          w_err_next   = 1'b0;
          w_state_next = W_DATA;
        end
      end
      W_DATA: begin
        if (s_axi_wvalid) begin
          mem_we     = w_beat_ok;
          w_err_next = w_err_beat;
          if (w_last_beat) begin
            w_bresp_next = w_err_beat ? RESP_SLVERR : RESP_OKAY;
            w_state_next = W_RESP;
          end else begin
            w_beat_next = w_beat_reg + 9'd1;
            w_addr_next = w_addr_reg + ADDR_STEP;
          end
        end
      end
      W_RESP: begin
        if (s_axi_bready) begin
          w_state_next = W_IDLE;
        end
      end
      default: w_state_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state_reg <= R_IDLE;
      r_addr_reg  <= '0;
      r_len_reg   <= '0;
      r_beat_reg  <= '0;
      r_id_reg    <= '0;
      r_last_reg  <= 1'b0;
      r_resp_reg  <= RESP_OKAY;
      r_zero_reg  <= 1'b1;
      w_state_reg <= W_IDLE;
      w_addr_reg  <= '0;
      w_len_reg   <= '0;
      w_beat_reg  <= '0;
      w_id_reg    <= '0;
      w_err_reg   <= 1'b0;
      w_bresp_reg <= RESP_OKAY;
    end else begin
      r_state_reg <= r_state_next;
      r_addr_reg  <= r_addr_next;
      r_len_reg   <= r_len_next;
      r_beat_reg  <= r_beat_next;
      r_id_reg    <= r_id_next;
      r_last_reg  <= r_last_next;
      r_resp_reg  <= r_resp_next;
      r_zero_reg  <= r_zero_next;
      w_state_reg <= w_state_next;
      w_addr_reg  <= w_addr_next;
      w_len_reg   <= w_len_next;
      w_beat_reg  <= w_beat_next;
      w_id_reg    <= w_id_next;
      w_err_reg   <= w_err_next;
      w_bresp_reg <= w_bresp_next;
    end
  end

  // r_zero_reg masks the RAM output so reset and out-of-range beats read as zero.
  assign s_axi_arready = (r_state_reg == R_IDLE);
  assign s_axi_rvalid  = (r_state_reg == R_DATA);
  assign s_axi_rid     = r_id_reg;
  assign s_axi_rdata   = r_zero_reg ? '0 : mem_rdata;
  assign s_axi_rresp   = r_resp_reg;
  assign s_axi_rlast   = r_last_reg;

  assign s_axi_awready = (w_state_reg == W_IDLE);
  assign s_axi_wready  = (w_state_reg == W_DATA);
  assign s_axi_bvalid  = (w_state_reg == W_RESP);
  assign s_axi_bid     = w_id_reg;
  assign s_axi_bresp   = w_bresp_reg;

endmodule

// File: tb/tb_axi_mem_responder.sv
// Directed bench for axi_mem_responder: a word-array model predicts every R
// and B beat, and a negedge monitor compares the live channels against it.
module tb_axi_mem_responder;

  localparam int IDW = 13;

  logic            clk = 1'b0;
  logic            reset;
  logic [IDW-1:0]  s_axi_awid;
  logic [63:0]     s_axi_awaddr;
  logic [7:0]      s_axi_awlen;
  logic [2:0]      s_axi_awsize;
  logic [1:0]      s_axi_awburst;
  logic            s_axi_awvalid, s_axi_awready;
  logic [63:0]     s_axi_wdata;
  logic [7:0]      s_axi_wstrb;
  logic            s_axi_wlast, s_axi_wvalid, s_axi_wready;
  logic [IDW-1:0]  s_axi_bid;
  logic [1:0]      s_axi_bresp;
  logic            s_axi_bvalid, s_axi_bready;
  logic [IDW-1:0]  s_axi_arid;
  logic [63:0]     s_axi_araddr;
  logic [7:0]      s_axi_arlen;
  logic [2:0]      s_axi_arsize;
  logic [1:0]      s_axi_arburst;
  logic            s_axi_arvalid, s_axi_arready;
  logic [IDW-1:0]  s_axi_rid;
  logic [63:0]     s_axi_rdata;
  logic [1:0]      s_axi_rresp;
  logic            s_axi_rlast, s_axi_rvalid, s_axi_rready;

  always #5 clk = ~clk;

  axi_mem_responder dut (
    .clk(clk), .reset(reset),
    .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
    .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp),
    .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
    .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready)
  );

  typedef struct {
    logic [IDW-1:0] id;
    logic [63:0]    data;
    logic [1:0]     resp;
    logic           last;
  } rbeat_t;

  typedef struct {
    logic [IDW-1:0] id;
    logic [1:0]     resp;
  } bexp_t;

  rbeat_t      exp_r[$];
  rbeat_t      got_r[$];
  bexp_t       exp_b[$];
  logic [63:0] mdl [1024];
  logic [63:0] wd  [16];
  logic [7:0]  ws  [16];
  int          n_vec = 0;
  int          n_err = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, want, $time);
    end
  endtask

  // 1024 words of 8 bytes starting at byte 0
  function automatic bit inr(input logic [63:0] a);
    return (a >> 3) < 64'd1024;
  endfunction

  task automatic expect_read(input logic [63:0] addr, input int len, input logic [IDW-1:0] id);
    for (int b = 0; b <= len; b++) begin
      logic [63:0] a;
      rbeat_t      e;
      a      = addr + 64'(8 * b);
      e.id   = id;
      e.last = (b == len);
      if (inr(a)) begin
        e.data = mdl[a[12:3]];
        e.resp = 2'b00;
      end else begin
        e.data = '0;
        e.resp = 2'b10;
      end
      exp_r.push_back(e);
    end
  endtask

  task automatic ar_send(input logic [63:0] addr, input logic [7:0] len, input logic [IDW-1:0] id);
    bit hs;
    int guard = 0;
    s_axi_araddr = addr; s_axi_arlen = len; s_axi_arid = id; s_axi_arvalid = 1'b1;
    do begin
      @(negedge clk); hs = s_axi_arready;
      @(posedge clk); #1; guard++;
    end while (!hs && guard < 100);
    if (!hs) check("ar_handshake_timeout", 64'(s_axi_arready), 64'd1);
    s_axi_arvalid = 1'b0;
  endtask

  task automatic aw_send(input logic [63:0] addr, input logic [7:0] len, input logic [IDW-1:0] id);
    bit hs;
    int guard = 0;
    s_axi_awaddr = addr; s_axi_awlen = len; s_axi_awid = id; s_axi_awvalid = 1'b1;
    do begin
      @(negedge clk); hs = s_axi_awready;
      @(posedge clk); #1; guard++;
    end while (!hs && guard < 100);
    if (!hs) check("aw_handshake_timeout", 64'(s_axi_awready), 64'd1);
    s_axi_awvalid = 1'b0;
  endtask

  task automatic w_beat(input logic [63:0] d, input logic [7:0] s, input logic last);
    bit hs;
    int guard = 0;
    s_axi_wdata = d; s_axi_wstrb = s; s_axi_wlast = last; s_axi_wvalid = 1'b1;
    do begin
      @(negedge clk); hs = s_axi_wready;
      @(posedge clk); #1; guard++;
    end while (!hs && guard < 100);
    if (!hs) check("w_handshake_timeout", 64'(s_axi_wready), 64'd1);
    s_axi_wvalid = 1'b0;
  endtask

  // Runs R until the expected queue is consumed; optionally checks 1-cycle latency.
  task automatic r_drain(input bit toggle, input bit check_first);
    int cyc = 0;
    while (exp_r.size() != 0 && cyc < 1000) begin
      s_axi_rready = toggle ? ((cyc % 2) == 0) : 1'b1;
      if (cyc == 0 && check_first) begin
        @(negedge clk);
        check("r_first_beat_latency", 64'(s_axi_rvalid), 64'd1);
      end
      @(posedge clk); #1; cyc++;
    end
    s_axi_rready = 1'b0;
    if (exp_r.size() != 0) begin
      check("r_drain_timeout", 64'(exp_r.size()), 64'd0);
      exp_r.delete();
    end
  endtask

  task automatic b_drain();
    int cyc = 0;
    while (exp_b.size() != 0 && cyc < 200) begin
      @(posedge clk); #1; cyc++;
    end
    if (exp_b.size() != 0) begin
      check("b_drain_timeout", 64'(exp_b.size()), 64'd0);
      exp_b.delete();
    end
  endtask

  task automatic do_read(input logic [63:0] addr, input logic [7:0] len,
                         input logic [IDW-1:0] id, input bit toggle);
    got_r.delete();
    expect_read(addr, int'(len), id);
    ar_send(addr, len, id);
    r_drain(toggle, 1'b1);
  endtask

  // Uses wd[]/ws[] as the beat payloads; the model decides the expected bresp.
  task automatic do_write(input logic [63:0] addr, input logic [7:0] len, input logic [IDW-1:0] id,
                          input bit bad_last, input int bdelay);
    bit    err = 1'b0;
    bexp_t e;
    for (int b = 0; b <= int'(len); b++) begin
      logic [63:0] a;
      a = addr + 64'(8 * b);
      if (inr(a)) begin
        for (int k = 0; k < 8; k++)
          if (ws[b][k]) mdl[a[12:3]][8*k +: 8] = wd[b][8*k +: 8];
      end else begin
        err = 1'b1;
      end
    end
    if (bad_last) err = 1'b1;
    e.id = id; e.resp = err ? 2'b10 : 2'b00;
    exp_b.push_back(e);
    s_axi_bready = (bdelay == 0);
    aw_send(addr, len, id);
    for (int b = 0; b <= int'(len); b++)
      w_beat(wd[b], ws[b], (b == int'(len)) ^ (bad_last && b == int'(len)));
    repeat (bdelay) begin @(posedge clk); #1; end
    s_axi_bready = 1'b1;
    b_drain();
  endtask

  // Per-cycle monitor: every visible R/B beat is compared with the model's prediction.
  initial begin : monitor
    bit             r_hold, b_hold;
    logic [63:0]    r_held;
    logic [IDW+1:0] b_held;
    rbeat_t         rb;
    r_hold = 1'b0; b_hold = 1'b0; r_held = '0; b_held = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        r_hold = 1'b0; b_hold = 1'b0;
      end else begin
        if (r_hold) begin
          check("r_hold_valid", 64'(s_axi_rvalid), 64'd1);
          check("r_hold_data", s_axi_rdata, r_held);
        end
        if (s_axi_rvalid) begin
          if (exp_r.size() == 0) check("r_unexpected", 64'(s_axi_rvalid), 64'd0);
          else begin
            check("rid", 64'(s_axi_rid), 64'(exp_r[0].id));
            check("rdata", s_axi_rdata, exp_r[0].data);
            check("rresp", 64'(s_axi_rresp), 64'(exp_r[0].resp));
            check("rlast", 64'(s_axi_rlast), 64'(exp_r[0].last));
            if (s_axi_rready) begin
              rb.id = s_axi_rid; rb.data = s_axi_rdata; rb.resp = s_axi_rresp; rb.last = s_axi_rlast;
              got_r.push_back(rb);
              void'(exp_r.pop_front());
            end
          end
        end
        r_hold = s_axi_rvalid && !s_axi_rready;
        r_held = s_axi_rdata;

        if (b_hold) check("b_hold", 64'({s_axi_bvalid, s_axi_bid, s_axi_bresp}), 64'({1'b1, b_held}));
        if (s_axi_bvalid) begin
          if (exp_b.size() == 0) check("b_unexpected", 64'(s_axi_bvalid), 64'd0);
          else begin
            check("bid", 64'(s_axi_bid), 64'(exp_b[0].id));
            check("bresp", 64'(s_axi_bresp), 64'(exp_b[0].resp));
            if (s_axi_bready) void'(exp_b.pop_front());
          end
        end
        b_hold = s_axi_bvalid && !s_axi_bready;
        b_held = {s_axi_bid, s_axi_bresp};
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    reset = 1'b1;
    s_axi_awid = '0; s_axi_awaddr = '0; s_axi_awlen = '0; s_axi_awsize = 3'd3; s_axi_awburst = 2'b01;
    s_axi_awvalid = 1'b0; s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 1'b0; s_axi_wvalid = 1'b0;
    s_axi_bready = 1'b1; s_axi_arid = '0; s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arsize = 3'd3;
    s_axi_arburst = 2'b01; s_axi_arvalid = 1'b0; s_axi_rready = 1'b0;
    for (int i = 0; i < 1024; i++) mdl[i] = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_arready", 64'(s_axi_arready), 64'd1);
    check("reset_awready", 64'(s_axi_awready), 64'd1);
    check("reset_wready", 64'(s_axi_wready), 64'd0);
    check("reset_rvalid", 64'(s_axi_rvalid), 64'd0);
    check("reset_bvalid", 64'(s_axi_bvalid), 64'd0);
    check("reset_rdata", s_axi_rdata, 64'd0);
    check("reset_rid_rresp_rlast", 64'({s_axi_rid, s_axi_rresp, s_axi_rlast}), 64'd0);
    check("reset_bid_bresp", 64'({s_axi_bid, s_axi_bresp}), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Preload words 0..15 with 100..115 in one 16-beat burst
    for (int i = 0; i < 16; i++) begin wd[i] = 64'(100 + i); ws[i] = 8'hFF; end
    do_write(64'h0, 8'd15, 13'd7, 1'b0, 0);

    // Single read
    wd[0] = 64'hDEADBEEF_01234567; ws[0] = 8'hFF;
    do_write(64'h40, 8'd0, 13'd1, 1'b0, 0);
    do_read(64'h40, 8'd0, 13'd5, 1'b0);
    check("single_count", 64'(got_r.size()), 64'd1);
    check("single_data", got_r[0].data, 64'hDEADBEEF_01234567);
    check("single_id_resp_last", 64'({got_r[0].id, got_r[0].resp, got_r[0].last}), 64'({13'd5, 2'b00, 1'b1}));

    // Burst read with rready toggling
    do_read(64'h0, 8'd7, 13'd3, 1'b1);
    check("burst_count", 64'(got_r.size()), 64'd8);
    check("burst_first", got_r[0].data, 64'd100);
    check("burst_last", got_r[7].data, 64'd107);
    check("burst_rlast_b7", 64'({got_r[6].last, got_r[7].last}), 64'b01);

    // Strobed write with delayed bready
    wd[0] = '1; ws[0] = 8'hFF;
    do_write(64'h80, 8'd0, 13'd2, 1'b0, 0);
    wd[0] = '0; ws[0] = 8'h0F;
    do_write(64'h80, 8'd0, 13'd9, 1'b0, 3);
    do_read(64'h80, 8'd0, 13'd9, 1'b0);
    check("strobe_readback", got_r[0].data, 64'hFFFFFFFF_00000000);

    // Out-of-range read/write at the end of memory
    wd[0] = 64'h5555AAAA_00001023; ws[0] = 8'hFF;
    do_write(64'h1FF8, 8'd0, 13'd4, 1'b0, 0);
    do_read(64'h1FF8, 8'd1, 13'd2, 1'b0);
    check("oor_beat1_resp", 64'(got_r[0].resp), 64'd0);
    check("oor_beat2", 64'({got_r[1].resp, got_r[1].last}), 64'({2'b10, 1'b1}));
    check("oor_beat2_data", got_r[1].data, 64'd0);
    wd[0] = 64'h0BAD; ws[0] = 8'hFF;
    do_write(64'h2000, 8'd0, 13'd8, 1'b0, 0);
    do_read(64'h0, 8'd0, 13'd1, 1'b0);
    check("oor_write_no_alias", got_r[0].data, 64'd100);

    // wlast asserted on the wrong beat
    wd[0] = 64'h1; ws[0] = 8'hFF;
    do_write(64'h100, 8'd0, 13'd10, 1'b1, 0);

    // Collision: word 9 written on the same edge that beat 9 loads
    got_r.delete();
    expect_read(64'h0, 15, 13'h11);
    ar_send(64'h0, 8'd15, 13'h11);
    s_axi_rready = 1'b1;
    repeat (7) @(posedge clk);
    #1;
    begin
      bexp_t e;
      e.id = 13'd4; e.resp = 2'b00;
      exp_b.push_back(e);
    end
    aw_send(64'h48, 8'd0, 13'd4);
    w_beat(64'h1234_5678_9ABC_DEF0, 8'hFF, 1'b1);
    mdl[9] = 64'h1234_5678_9ABC_DEF0;
    r_drain(1'b0, 1'b0);
    b_drain();
    check("collision_old", got_r[9].data, 64'd109);
    do_read(64'h48, 8'd0, 13'd4, 1'b0);
    check("collision_new", got_r[0].data, 64'h1234_5678_9ABC_DEF0);

    // Reset during beat 3 of a read and during W_DATA of a write
    aw_send(64'hA0, 8'd3, 13'd6);
    w_beat(64'hCAFEF00D_12345678, 8'hFF, 1'b0);
    mdl[20] = 64'hCAFEF00D_12345678;
    expect_read(64'h0, 7, 13'd1);
    ar_send(64'h0, 8'd7, 13'd1);
    s_axi_rready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_r.delete();
    @(negedge clk);
    check("rst_mid_rvalid", 64'(s_axi_rvalid), 64'd0);
    check("rst_mid_bvalid", 64'(s_axi_bvalid), 64'd0);
    check("rst_mid_arready", 64'(s_axi_arready), 64'd1);
    check("rst_mid_awready", 64'(s_axi_awready), 64'd1);
    check("rst_mid_wready", 64'(s_axi_wready), 64'd0);
    @(posedge clk); #1;
    s_axi_rready = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    do_read(64'hA0, 8'd0, 13'd12, 1'b0);
    check("rst_mid_data_kept", got_r[0].data, 64'hCAFEF00D_12345678);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
